// File: rtl/stack_seq.sv
// ----------------------------------------------------------------------------
// stack_seq
// Multi-cycle stack access sequencer for the EVM-style core. Owns the stack
// pointer and drives a single-port stack RAM, turning one opcode's stack
// effect (pop 0..2 operands, push 0..1 result) into a sequence of RAM reads
// and at most one RAM write. Underflow and overflow are detected when the
// operation is accepted; an erroneous op makes no RAM access and leaves sp
// untouched.
//
// Optional build macro: STACK_SEQ_PERF_EN adds the saturating performance
// counters op_count, err_count and stall_cycles.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   op_valid/op_ready     operation handshake (ready only in IDLE)
//   op_pops, op_push      stack effect of the operation (pops 3 acts as 2)
//   opnd_valid            operands valid, held for every EXEC cycle
//   opnd0, opnd1          former top (sp-1) and second (sp-2) of stack
//   res_valid, res_data   ALU result, sampled only in EXEC when pushing
//   done, err, err_code   completion pulse, abort flag, sticky error code
//   sp                    current stack depth 0..DEPTH
//   mem_en, mem_we,
//   mem_addr, mem_wdata   RAM request
//   mem_rdata             RAM read data, one cycle after a read request
//   op_count, err_count,
//   stall_cycles          performance counters (STACK_SEQ_PERF_EN only)
// ----------------------------------------------------------------------------
module stack_seq #(
    parameter  int WIDTH  = 256,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_pops,
    input  logic              op_push,
    output logic              opnd_valid,
    output logic [WIDTH-1:0]  opnd0,
    output logic [WIDTH-1:0]  opnd1,
    input  logic              res_valid,
    input  logic [WIDTH-1:0]  res_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   sp,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
`ifdef STACK_SEQ_PERF_EN
    ,
    output logic [31:0]       op_count,
    output logic [15:0]       err_count,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_CAP,
        S_EXEC,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0]      ERR_NONE  = 2'b00;
    localparam logic [1:0]      ERR_UNDER = 2'b01;
    localparam logic [1:0]      ERR_OVER  = 2'b10;
    localparam logic [ADDR_W:0] ONE_W     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO_W     = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [ADDR_W:0]  sp_q, sp_d;
    logic [1:0]       pops_q, pops_d;
    logic             push_q, push_d;
    logic [1:0]       errCode_q, errCode_d;
    logic [WIDTH-1:0] opnd0_q, opnd0_d;
    logic [WIDTH-1:0] opnd1_q, opnd1_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [1:0]       reqPops;
    logic [ADDR_W:0]  reqPopsW;
    logic [ADDR_W:0]  popsW;
    logic [ADDR_W:0]  pushW;
    logic             underflow;
    logic             overflow;

    // Normalise the requested pop count (3 behaves as 2) and evaluate the
    // error checks against the current depth. Overflow is only meaningful
    // once underflow is ruled out, since then sp-pops cannot wrap; all of
    // this is done one bit wider than the RAM address so DEPTH+1 fits.
    assign reqPops   = (op_pops == 2'd3) ? 2'd2 : op_pops;
    assign reqPopsW  = (ADDR_W+1)'(reqPops);
    assign popsW     = (ADDR_W+1)'(pops_q);
    assign pushW     = (ADDR_W+1)'(push_q);
    assign underflow = (reqPopsW > sp_q);
    assign overflow  = op_push && ((sp_q - reqPopsW + ONE_W) > DEPTH_W);

    // State and datapath registers. A reset at any point abandons the
    // current operation: the sequencer returns to IDLE with an empty stack
    // and, because the RAM strobes are decoded from the state, no write or
    // done pulse can leak out afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sp_q      <= '0;
            pops_q    <= '0;
            push_q    <= 1'b0;
            errCode_q <= ERR_NONE;
            opnd0_q   <= '0;
            opnd1_q   <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            pops_q    <= pops_d;
            push_q    <= push_d;
            errCode_q <= errCode_d;
            opnd0_q   <= opnd0_d;
            opnd1_q   <= opnd1_d;
            result_q  <= result_d;
        end
    end

    // Next-state and output decode. Reads are pipelined: the address issued
    // in RD0 (sp-1) returns during RD1 or CAP, and the address issued in RD1
    // (sp-2) returns during CAP. The result lands at sp-pops, which for a
    // pop-and-push at full depth overwrites the old top in place.
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        pops_d     = pops_q;
        push_d     = push_q;
        errCode_d  = errCode_q;
        opnd0_d    = opnd0_q;
        opnd1_d    = opnd1_q;
        result_d   = result_q;
        op_ready   = 1'b0;
        opnd_valid = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    pops_d  = reqPops;
                    push_d  = op_push;
                    opnd0_d = '0;
                    opnd1_d = '0;
                    if (underflow) begin
                        errCode_d = ERR_UNDER;
                        state_d   = S_ERR;
                    end else if (overflow) begin
                        errCode_d = ERR_OVER;
                        state_d   = S_ERR;
                    end else begin
                        errCode_d = ERR_NONE;
                        state_d   = (reqPops == 2'd0) ? S_EXEC : S_RD0;
                    end
                end
            end
            S_RD0: begin
                mem_en   = 1'b1;
                mem_addr = ADDR_W'(sp_q - ONE_W);
                state_d  = (pops_q == 2'd2) ? S_RD1 : S_CAP;
            end
            S_RD1: begin
                mem_en   = 1'b1;
                mem_addr = ADDR_W'(sp_q - TWO_W);
                opnd0_d  = mem_rdata;
                state_d  = S_CAP;
            end
            S_CAP: begin
                if (pops_q == 2'd2) begin
                    opnd1_d = mem_rdata;
                end else begin
                    opnd0_d = mem_rdata;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                opnd_valid = 1'b1;
                if (!push_q) begin
                    state_d = S_DONE;
                end else if (res_valid) begin
                    result_d = res_data;
                    state_d  = S_WR;
                end
            end
            S_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(sp_q - popsW);
                mem_wdata = result_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                sp_d    = sp_q - popsW + pushW;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sp       = sp_q;
    assign err_code = errCode_q;
    assign opnd0    = opnd0_q;
    assign opnd1    = opnd1_q;

`ifdef STACK_SEQ_PERF_EN
    logic [31:0] opCount_q;
    logic [15:0] errCount_q;
    logic [31:0] stallCycles_q;

    // Saturating event counters. Stall cycles are EXEC cycles in which a
    // push operation is still waiting for the ALU result.
    always_ff @(posedge clk) begin
        if (rst) begin
            opCount_q     <= '0;
            errCount_q    <= '0;
            stallCycles_q <= '0;
        end else begin
            if (done && (opCount_q != '1)) begin
                opCount_q <= opCount_q + 32'd1;
            end
            if (err && (errCount_q != '1)) begin
                errCount_q <= errCount_q + 16'd1;
            end
            if ((state_q == S_EXEC) && push_q && !res_valid && (stallCycles_q != '1)) begin
                stallCycles_q <= stallCycles_q + 32'd1;
            end
        end
    end

    assign op_count     = opCount_q;
    assign err_count    = errCount_q;
    assign stall_cycles = stallCycles_q;
`endif

endmodule

// File: tb/tb_stack_seq.sv
// ----------------------------------------------------------------------------
// tb_stack_seq
// Self-checking bench for stack_seq. A behavioural RAM answers the DUT's
// memory requests; a queue-based stack model supplies expected operands,
// write addresses, depth and error codes. A directed vector table covers the
// basic cases, hand-written sequences cover full-stack and reset corners,
// and a randomised phase exercises arbitrary op mixes against the model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stack_seq;

    localparam int WIDTH = 256;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_pops;
    logic             op_push;
    logic             opnd_valid;
    logic [WIDTH-1:0] opnd0;
    logic [WIDTH-1:0] opnd1;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [AW:0]      sp;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
`ifdef STACK_SEQ_PERF_EN
    logic [31:0]      op_count;
    logic [15:0]      err_count;
    logic [31:0]      stall_cycles;
`endif

    stack_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_pops(op_pops), .op_push(op_push),
        .opnd_valid(opnd_valid), .opnd0(opnd0), .opnd1(opnd1),
        .res_valid(res_valid), .res_data(res_data),
        .done(done), .err(err), .err_code(err_code), .sp(sp),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef STACK_SEQ_PERF_EN
        , .op_count(op_count), .err_count(err_count), .stall_cycles(stall_cycles)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one cycle of read latency.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Safety net in case the sequencer locks up completely.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    int nCompared   = 0;
    int nMismatched = 0;
    bit noiseEn     = 0;

    logic [WIDTH-1:0] model[$];
    int tbOps, tbErrs;

    // Observations from the most recent operation.
    bit               obsTimeout, obsErr, obsReadyAfter, obsDoneAfter;
    logic [1:0]       obsCode, obsCodeAfter;
    int               obsCyc, obsWrCnt, obsMemAcc, obsOpndCnt;
    logic [AW-1:0]    obsWrAddr;
    logic [WIDTH-1:0] obsWrData, obsOp0, obsOp1;
    logic [AW:0]      obsSp;
    logic [31:0]      obsStall;

    typedef struct {
        bit               doReset;
        logic [1:0]       pops;
        bit               push;
        logic [WIDTH-1:0] res;
        int               stall;
        bit               expErr;
        logic [1:0]       expCode;
        int               expCyc;
        logic [WIDTH-1:0] expOp0;
        logic [WIDTH-1:0] expOp1;
        int               expSp;
        int               expWrAddr;
    } vec_t;

    task automatic checkVal(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Accept-to-done latency for each stack effect, without result stalls.
    function automatic int specLatency(input int p, input bit push);
        case ({p[1:0], push})
            3'b00_0: specLatency = 2;
            3'b00_1: specLatency = 3;
            3'b01_0: specLatency = 4;
            3'b01_1: specLatency = 5;
            3'b10_0: specLatency = 5;
            default: specLatency = 6;
        endcase
    endfunction

    task automatic doReset(input string tag);
        rst = 1'b1; op_valid = 1'b0; res_valid = 1'b0; op_pops = '0; op_push = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkVal({tag, ".ready"}, op_ready, 1);
        checkVal({tag, ".sp"}, sp, 0);
        checkVal({tag, ".done"}, done, 0);
        checkVal({tag, ".err"}, err, 0);
        checkVal({tag, ".errCode"}, err_code, 0);
        checkVal({tag, ".opndValid"}, opnd_valid, 0);
        checkVal({tag, ".opnd0"}, opnd0, 0);
        checkVal({tag, ".opnd1"}, opnd1, 0);
        checkVal({tag, ".memEn"}, mem_en, 0);
        checkVal({tag, ".memWe"}, mem_we, 0);
`ifdef STACK_SEQ_PERF_EN
        checkVal({tag, ".opCount"}, op_count, 0);
        checkVal({tag, ".errCount"}, err_count, 0);
        checkVal({tag, ".stall"}, stall_cycles, 0);
`endif
        model.delete();
        tbOps = 0;
        tbErrs = 0;
    endtask

    // Present one operation, then follow it cycle by cycle until done,
    // feeding the result after the requested number of stall cycles.
    task automatic applyStimulus(input logic [1:0] pops, input bit push, input logic [WIDTH-1:0] res, input int stall);
        int  stallLeft;
        bit  fin;
        logic [31:0] stallStart;
        @(negedge clk);
        op_valid = 1'b1; op_pops = pops; op_push = push; res_data = res; res_valid = 1'b0;
        obsTimeout = 0; obsErr = 0; obsCode = '0; obsCyc = 0; obsWrCnt = 0; obsMemAcc = 0;
        obsOpndCnt = 0; obsWrAddr = '0; obsWrData = '0; obsOp0 = '0; obsOp1 = '0;
        stallStart = '0;
`ifdef STACK_SEQ_PERF_EN
        stallStart = stall_cycles;
`endif
        stallLeft = stall;
        fin = 0;
        for (int c = 1; c <= 60 && !fin; c++) begin
            @(negedge clk);
            op_valid = 1'b0;
            if (mem_en) obsMemAcc++;
            if (mem_en && mem_we) begin
                obsWrCnt++;
                obsWrAddr = mem_addr;
                obsWrData = mem_wdata;
            end
            if (opnd_valid) begin
                if (obsOpndCnt == 0) begin
                    obsOp0 = opnd0;
                    obsOp1 = opnd1;
                end
                obsOpndCnt++;
                if (stallLeft > 0) begin
                    res_valid = 1'b0;
                    stallLeft--;
                end else begin
                    res_valid = 1'b1;
                end
            end else if (noiseEn) begin
                res_valid = 1'($urandom_range(0, 1));
            end else begin
                res_valid = 1'b0;
            end
            if (done) begin
                fin = 1;
                obsCyc = c;
                obsErr = err;
                obsCode = err_code;
            end
        end
        res_valid = 1'b0;
        obsTimeout = !fin;
        @(negedge clk);
        obsSp = sp;
        obsCodeAfter = err_code;
        obsReadyAfter = op_ready;
        obsDoneAfter = done;
        obsStall = '0;
`ifdef STACK_SEQ_PERF_EN
        obsStall = stall_cycles - stallStart;
`endif
    endtask

    task automatic checkOutput(input string tag, input bit expErr, input logic [1:0] expCode, input int expCyc,
                               input logic [WIDTH-1:0] expOp0, input logic [WIDTH-1:0] expOp1, input int expSp,
                               input int expWrAddr, input logic [WIDTH-1:0] expWrData, input int expOpndCnt,
                               input int expStall);
        checkVal({tag, ".timeout"}, obsTimeout, 0);
        checkVal({tag, ".err"}, obsErr, expErr);
        checkVal({tag, ".errCode"}, obsCode, expCode);
        checkVal({tag, ".cycles"}, obsCyc, expCyc);
        checkVal({tag, ".sp"}, obsSp, expSp);
        checkVal({tag, ".codeHeld"}, obsCodeAfter, expCode);
        checkVal({tag, ".readyAfter"}, obsReadyAfter, 1);
        checkVal({tag, ".donePulse"}, obsDoneAfter, 0);
        checkVal({tag, ".writes"}, obsWrCnt, (expWrAddr >= 0) ? 1 : 0);
        if (expWrAddr >= 0) begin
            checkVal({tag, ".wrAddr"}, obsWrAddr, expWrAddr);
            checkVal({tag, ".wrData"}, obsWrData, expWrData);
        end
        if (expErr) begin
            checkVal({tag, ".memAccess"}, obsMemAcc, 0);
            checkVal({tag, ".opndCycles"}, obsOpndCnt, 0);
        end else begin
            checkVal({tag, ".opndCycles"}, obsOpndCnt, expOpndCnt);
            checkVal({tag, ".opnd0"}, obsOp0, expOp0);
            checkVal({tag, ".opnd1"}, obsOp1, expOp1);
        end
`ifdef STACK_SEQ_PERF_EN
        checkVal({tag, ".stallCount"}, obsStall, expStall);
`else
        if (expStall < 0) checkVal({tag, ".stallArg"}, expStall, 0);
`endif
    endtask

    // Stack reference: applies the operation's effect to the queue and
    // returns what the sequencer should report.
    task automatic modelStep(input logic [1:0] pops, input bit push, input logic [WIDTH-1:0] res, input int stall,
                             output bit eErr, output logic [1:0] eCode, output int eCyc,
                             output logic [WIDTH-1:0] eOp0, output logic [WIDTH-1:0] eOp1,
                             output int eSp, output int eWr);
        int p;
        int n;
        p = (pops == 2'd3) ? 2 : int'(pops);
        n = model.size();
        eOp0 = '0; eOp1 = '0; eWr = -1; eErr = 0; eCode = 2'b00; eCyc = 1; eSp = n;
        if (p > n) begin
            eErr = 1; eCode = 2'b01;
        end else if (push && (n - p + 1 > DEPTH)) begin
            eErr = 1; eCode = 2'b10;
        end else begin
            if (p >= 1) eOp0 = model[n-1];
            if (p == 2) eOp1 = model[n-2];
            repeat (p) void'(model.pop_back());
            if (push) begin
                eWr = model.size();
                model.push_back(res);
            end
            eSp = model.size();
            eCyc = specLatency(p, push) + (push ? stall : 0);
        end
        tbOps++;
        if (eErr) tbErrs++;
    endtask

    task automatic runModelOp(input string tag, input logic [1:0] pops, input bit push,
                              input logic [WIDTH-1:0] res, input int stall);
        bit eErr; logic [1:0] eCode; int eCyc; logic [WIDTH-1:0] eOp0, eOp1; int eSp, eWr;
        modelStep(pops, push, res, stall, eErr, eCode, eCyc, eOp0, eOp1, eSp, eWr);
        applyStimulus(pops, push, res, stall);
        checkOutput(tag, eErr, eCode, eCyc, eOp0, eOp1, eSp, eWr, res,
                    push ? stall + 1 : 1, (push && !eErr) ? stall : 0);
    endtask

    initial begin
        vec_t vecs[$];
        bit   sawBad;

        rst = 1'b1; op_valid = 1'b0; op_pops = '0; op_push = 1'b0; res_valid = 1'b0; res_data = '0;

        // Directed vectors: doReset, pops, push, res, stall, expErr, expCode,
        // expCyc, expOp0, expOp1, expSp, expWrAddr.
        vecs.push_back('{1, 2'd0, 1, 256'h2A, 0, 0, 2'b00, 3, 256'h0,  256'h0,  1, 0});
        vecs.push_back('{1, 2'd0, 1, 256'h03, 0, 0, 2'b00, 3, 256'h0,  256'h0,  1, 0});
        vecs.push_back('{0, 2'd0, 1, 256'h05, 0, 0, 2'b00, 3, 256'h0,  256'h0,  2, 1});
        vecs.push_back('{0, 2'd2, 1, 256'h08, 0, 0, 2'b00, 6, 256'h05, 256'h03, 1, 0});
        vecs.push_back('{1, 2'd1, 0, 256'h0,  0, 1, 2'b01, 1, 256'h0,  256'h0,  0, -1});
        vecs.push_back('{0, 2'd0, 0, 256'h0,  0, 0, 2'b00, 2, 256'h0,  256'h0,  0, -1});
        vecs.push_back('{0, 2'd0, 1, 256'h11, 0, 0, 2'b00, 3, 256'h0,  256'h0,  1, 0});
        vecs.push_back('{0, 2'd0, 1, 256'h22, 2, 0, 2'b00, 5, 256'h0,  256'h0,  2, 1});
        vecs.push_back('{0, 2'd3, 0, 256'h0,  0, 0, 2'b00, 5, 256'h22, 256'h11, 0, -1});
        vecs.push_back('{0, 2'd0, 1, 256'h33, 0, 0, 2'b00, 3, 256'h0,  256'h0,  1, 0});
        vecs.push_back('{0, 2'd2, 1, 256'h44, 0, 1, 2'b01, 1, 256'h0,  256'h0,  1, -1});
        vecs.push_back('{0, 2'd1, 0, 256'h0,  0, 0, 2'b00, 4, 256'h33, 256'h0,  0, -1});
        vecs.push_back('{0, 2'd1, 1, 256'h55, 1, 1, 2'b01, 1, 256'h0,  256'h0,  0, -1});
        vecs.push_back('{0, 2'd0, 1, 256'h66, 0, 0, 2'b00, 3, 256'h0,  256'h0,  1, 0});
        vecs.push_back('{0, 2'd1, 1, 256'h77, 0, 0, 2'b00, 5, 256'h66, 256'h0,  1, 0});

        foreach (vecs[i]) begin
            bit dErr; logic [1:0] dCode; int dCyc; logic [WIDTH-1:0] dOp0, dOp1; int dSp, dWr;
            string tag;
            tag = $sformatf("vec%0d", i);
            if (vecs[i].doReset) doReset({tag, ".reset"});
            modelStep(vecs[i].pops, vecs[i].push, vecs[i].res, vecs[i].stall,
                      dErr, dCode, dCyc, dOp0, dOp1, dSp, dWr);
            applyStimulus(vecs[i].pops, vecs[i].push, vecs[i].res, vecs[i].stall);
            checkOutput(tag, vecs[i].expErr, vecs[i].expCode, vecs[i].expCyc, vecs[i].expOp0,
                        vecs[i].expOp1, vecs[i].expSp, vecs[i].expWrAddr, vecs[i].res,
                        vecs[i].push ? vecs[i].stall + 1 : 1,
                        (vecs[i].push && !vecs[i].expErr) ? vecs[i].stall : 0);
        end

        // Full stack: fill to DEPTH, overflow on a pure push, then a legal
        // pop-and-push that replaces the top in place.
        doReset("fill.reset");
        for (int i = 0; i < DEPTH; i++) begin
            runModelOp($sformatf("fill%0d", i), 2'd0, 1'b1, WIDTH'(256 + i), 0);
        end
        runModelOp("ovf", 2'd0, 1'b1, 256'h99, 0);
        checkVal("ovf.code", obsCode, 2'b10);
        checkVal("ovf.sp", obsSp, DEPTH);
        runModelOp("replace", 2'd1, 1'b1, 256'h77, 0);
        checkVal("replace.addr", obsWrAddr, DEPTH - 1);
        checkVal("replace.data", obsWrData, 256'h77);
        checkVal("replace.sp", obsSp, DEPTH);

        // Result arrives after four stalled EXEC cycles.
        runModelOp("stall4", 2'd2, 1'b1, 256'hAB, 4);
        checkVal("stall4.opndCycles", obsOpndCnt, 5);
        checkVal("stall4.writes", obsWrCnt, 1);
`ifdef STACK_SEQ_PERF_EN
        checkVal("stall4.stallCount", obsStall, 4);
        checkVal("fill.opCount", op_count, tbOps);
        checkVal("fill.errCount", err_count, tbErrs);
`endif

        // Reset asserted while the second read of a pops2 op is in flight.
        @(negedge clk);
        op_valid = 1'b1; op_pops = 2'd2; op_push = 1'b1; res_data = 256'hDEAD;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        checkVal("rstMid.inRead", mem_en && !mem_we, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("rstMid.ready", op_ready, 1);
        checkVal("rstMid.sp", sp, 0);
        checkVal("rstMid.opndValid", opnd_valid, 0);
        sawBad = done || mem_we;
        res_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || mem_we || !op_ready) sawBad = 1;
        end
        res_valid = 1'b0;
        checkVal("rstMid.quiet", sawBad, 0);
        model.delete();
        tbOps = 0;
        tbErrs = 0;

        // Randomised op mix against the stack model; the first half leans on
        // pushes so the stack reaches full depth and overflows.
        doReset("rand.reset");
        noiseEn = 1;
        for (int i = 0; i < 250; i++) begin
            logic [1:0]       rPops;
            bit               rPush;
            int               rStall;
            logic [WIDTH-1:0] rRes;
            if (i < 125) rPops = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
            else         rPops = 2'($urandom_range(0, 3));
            rPush  = ($urandom_range(0, 9) < 7);
            rStall = rPush ? $urandom_range(0, 3) : 0;
            for (int k = 0; k < WIDTH / 32; k++) rRes[k*32 +: 32] = $urandom;
            runModelOp($sformatf("rand%0d", i), rPops, rPush, rRes, rStall);
        end
        noiseEn = 0;
`ifdef STACK_SEQ_PERF_EN
        checkVal("rand.opCount", op_count, tbOps);
        checkVal("rand.errCount", err_count, tbErrs);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
Multi-cycle stack access sequencer for the EVM-style core. It owns the stack pointer and the single-port stack RAM, and turns one opcode's stack effect (pop 0-2 operands, push 0-1 result) into a RAM read/write sequence. It checks underflow and overflow and reports them. It sits between the instruction decoder/ALU and the stack memory, replacing direct multi-port array access.

Parameters:
WIDTH, 256, stack word width in bits
DEPTH, 32, stack entries (power of two)
ADDR_W, $clog2(DEPTH), RAM address width (localparam; not overridable)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_valid  in  1  decoder presents a stack operation
op_ready  out  1  high only in IDLE; transfer on op_valid&&op_ready
op_pops  in  2  operands to pop (0,1,2); value 3 treated as 2
op_push  in  1  operation pushes one result
opnd_valid  out  1  opnd0/opnd1 valid; held high throughout EXEC
opnd0  out  WIDTH  former top of stack (sp-1); 0 if pops==0
opnd1  out  WIDTH  former second (sp-2); 0 if pops<2
res_valid  in  1  ALU result valid; sampled only in EXEC when op_push
res_data  in  WIDTH  result word to push
done  out  1  one-cycle pulse at operation completion
err  out  1  qualifies done: operation aborted
err_code  out  2  00 none, 01 underflow, 10 overflow; held until next accepted op
sp  out  ADDR_W+1  current depth, 0..DEPTH
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  WIDTH  RAM write data
mem_rdata  in  WIDTH  RAM read data, valid 1 cycle after mem_en&&!mem_we

Behaviour:
- Reset: state IDLE; sp=0; op_ready=1; opnd_valid=done=err=0; err_code=00; opnd0=opnd1=0; mem_en=mem_we=0. Reset mid-operation abandons the op: no write, sp=0, no done pulse.
- States: IDLE, RD0, RD1, CAP, EXEC, WR, DONE, ERR.
- On accept, latch pops/push and clear err_code. Check underflow (pops>sp) first, then overflow (push && sp-pops+1>DEPTH). On either error: go to ERR, make no RAM access, leave sp unchanged.
- ERR (1 cycle): done=1, err=1, err_code set; next state IDLE.
- pops==0: go to EXEC. pops>=1: go to RD0.
- RD0: mem_en=1, addr=sp-1. Next state RD1 if pops==2, else CAP.
- RD1: mem_en=1, addr=sp-2; capture mem_rdata into opnd0. Next state CAP.
- CAP: capture mem_rdata into opnd1 if pops==2, else into opnd0. Next state EXEC.
- EXEC: opnd_valid=1.
  - If !push: next state DONE.
  - If push: stay in EXEC until res_valid; then latch res_data and go to WR.
- WR: mem_en=mem_we=1, addr=sp-pops, wdata=latched result. Next state DONE.
- DONE: done=1, err=0; sp <= sp-pops+push. Next state IDLE.
- Cycle counts from the accept edge to done: pops2/push1 = 6 (res_valid at first EXEC cycle); pops1/push1 = 5; pops0/push1 = 3; pops2/push0 = 5; pops0/push0 = 2.
- Boundaries:
  - sp==DEPTH with pops>=1 and push is legal (replace in place).
  - sp==DEPTH with pops==0 and push is overflow.
  - sp==0 with pops==1 is underflow.
- Address arithmetic is done at ADDR_W+1 bits; only legal, in-range addresses are ever issued.
- op_valid outside IDLE is ignored. res_valid outside EXEC is ignored.

Optional Feature:
STACK_SEQ_PERF_EN
- Defined: adds output ports op_count[31:0] and err_count[15:0].
  - op_count increments on every done pulse. err_count increments on every done with err.
  - Both saturate at all-ones and reset to 0.
  - Adds an output stall_cycles[31:0]: counts EXEC cycles spent waiting with res_valid low; saturates.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then op pops0/push1 with res_data=0x2A -> RAM write addr0 data 0x2A; done 3 cycles after accept; sp=1; err=0.
- Push 0x03 then 0x05, then op pops2/push1 with res=0x08 -> opnd0=0x05, opnd1=0x03 while opnd_valid; write addr0=0x08; sp=1; accept-to-done 6 cycles.
- sp=0, op pops1/push0 -> ERR: done&&err, err_code=01, no mem_en asserted, sp stays 0; next good op clears err_code to 00.
- Fill to sp=32, then pops0/push1 -> err_code=10, sp=32. Then pops1/push1 with res=0x77 -> legal write addr31=0x77, sp=32.
- pops2/push1 with res_valid held low 4 cycles in EXEC -> opnd_valid high 5 cycles, single write after res_valid; with STACK_SEQ_PERF_EN, stall_cycles=4.
- Assert rst during RD1 of a pops2 op -> next cycle state IDLE, sp=0, op_ready=1, no write and no done pulse.
